regfile_wb_scheduler: RTL and testbench

Shares the register file's single write port between NREQ writeback sources (ALU, load unit, multiply unit) using round-robin arbitration. It drives a registered write_en/write_addr/write_data to the register file. It also keeps a 16-entry pending-write scoreboard, which lets the issue stage detect RAW and WAW hazards on the register file's two read ports.

---
 rtl/regfile_wb_scheduler.sv | 145 ++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: round-robin share of the register-file write port plus a pending-write scoreboard.
// Latency: grant is combinational; the granted write reaches rf_write_* one cycle after the transfer.
// Backpressure: one requester is granted per cycle (req_ready); issue_ready stalls re-reservation of a pending register.
// Optional feature macro: WB_BYPASS_EN (adds bypassA/bypassB/bypass_data and bypass-aware hazard).
module regfile_wb_scheduler #(
  parameter int NREQ = 3,
  parameter int AW   = 4,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  output logic                 issue_ready,
  input  logic [AW-1:0]        chk_addrA,
  input  logic [AW-1:0]        chk_addrB,
  output logic                 hazard,
  output logic                 rf_write_en,
  output logic [AW-1:0]        rf_write_addr,
  output logic [DW-1:0]        rf_write_data,
  output logic [(2**AW)-1:0]   busy
`ifdef WB_BYPASS_EN
  ,
  output logic                 bypassA,
  output logic                 bypassB,
  output logic [DW-1:0]        bypass_data
`endif
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 2**AW;

  // Adds an offset (< NREQ) to a requester index, wrapping modulo NREQ.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            xfer;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            clr_issue_addr;

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[wrap_add(rr_ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_add(rr_ptr, k);
      end
    end
  end

  assign xfer = gnt_any & ~RESET;

  // One-hot grant; nothing is granted while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  // Select the granted requester's destination and data.
  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        gnt_addr = req_addr[i*AW +: AW];
        gnt_data = req_data[i*DW +: DW];
      end
    end
  end

  // Pointer moves past the winner so it gets lowest priority next round.
  always_ff @(posedge clk) begin
    if (RESET) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= wrap_add(gnt_idx, 1);
    end
  end

  // Registered write port; address/data hold when no transfer happens.
  always_ff @(posedge clk) begin
    if (RESET) begin
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
    end else begin
      rf_write_en <= xfer;
      if (xfer) begin
        rf_write_addr <= gnt_addr;
        rf_write_data <= gnt_data;
      end
    end
  end

  // Per-register reservation (issue) and completion (write) decode.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      set_vec[r] = issue_en & issue_ready & (issue_addr == AW'(r));
      clr_vec[r] = rf_write_en & (rf_write_addr == AW'(r));
    end
  end

  // Scoreboard: a reservation beats a completion landing on the same register.
  always_ff @(posedge clk) begin
    if (RESET) begin
      busy <= '0;
    end else begin
      busy <= set_vec | (busy & ~clr_vec);
    end
  end

  // A pending register may be re-reserved only in the cycle its write completes.
  assign clr_issue_addr = rf_write_en & (rf_write_addr == issue_addr);
  assign issue_ready    = ~RESET & (~busy[issue_addr] | clr_issue_addr);

`ifdef WB_BYPASS_EN
  // Forward the in-flight write so the issue stage need not wait for the RF update.
  assign bypassA     = rf_write_en & (rf_write_addr == chk_addrA);
  assign bypassB     = rf_write_en & (rf_write_addr == chk_addrB);
  assign bypass_data = rf_write_data;
  assign hazard      = (busy[chk_addrA] & ~bypassA) | (busy[chk_addrB] & ~bypassB);
`else
  // The RF read still shows the old value during the write cycle, so busy alone decides.
  assign hazard      = busy[chk_addrA] | busy[chk_addrB];
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios followed by random traffic.
// Expected values come from a behavioural model of arbitration, write path and scoreboard.
// Inputs change on the falling edge; outputs are sampled 1-2 ns later.
module tb_regfile_wb_scheduler;
  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 16;

  logic                clk = 1'b0;
  logic                RESET;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic                issue_en;
  logic [AW-1:0]       issue_addr;
  logic                issue_ready;
  logic [AW-1:0]       chk_addrA;
  logic [AW-1:0]       chk_addrB;
  logic                hazard;
  logic                rf_write_en;
  logic [AW-1:0]       rf_write_addr;
  logic [DW-1:0]       rf_write_data;
  logic [15:0]         busy;
`ifdef WB_BYPASS_EN
  logic                bypassA;
  logic                bypassB;
  logic [DW-1:0]       bypass_data;
`endif

  regfile_wb_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .chk_addrA(chk_addrA), .chk_addrB(chk_addrB), .hazard(hazard),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .busy(busy)
`ifdef WB_BYPASS_EN
    , .bypassA(bypassA), .bypassB(bypassB), .bypass_data(bypass_data)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_ptr   = 0;
  bit m_busy[16];
  bit m_wen   = 0;
  int m_waddr = 0;
  int m_wdata = 0;
  int last_g  = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (RESET) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Checks every output against the model, then advances one clock and updates the model.
  task automatic cycle();
    int          g;
    bit          ir;
    bit          bya, byb, hz;
    logic [15:0] eb;
    logic [2:0]  er;
    #1;
    g  = exp_grant();
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    ir = !RESET && (!m_busy[issue_addr] || (m_wen && m_waddr == int'(issue_addr)));
    bya = 0;
    byb = 0;
`ifdef WB_BYPASS_EN
    bya = m_wen && m_waddr == int'(chk_addrA);
    byb = m_wen && m_waddr == int'(chk_addrB);
`endif
    hz = (m_busy[chk_addrA] && !bya) || (m_busy[chk_addrB] && !byb);
    for (int r = 0; r < 16; r++) eb[r] = m_busy[r];
    chk("req_ready", req_ready, er);
    chk("issue_ready", issue_ready, ir);
    chk("hazard", hazard, hz);
    chk("rf_write_en", rf_write_en, m_wen);
    chk("rf_write_addr", rf_write_addr, m_waddr);
    chk("rf_write_data", rf_write_data, m_wdata);
    chk("busy", busy, eb);
`ifdef WB_BYPASS_EN
    chk("bypassA", bypassA, bya);
    chk("bypassB", bypassB, byb);
    chk("bypass_data", bypass_data, m_wdata);
`endif
    last_g = g;
    @(posedge clk);
    if (RESET) begin
      m_ptr = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
      for (int r = 0; r < 16; r++) m_busy[r] = 0;
    end else begin
      if (m_wen) m_busy[m_waddr] = 0;
      if (issue_en && ir) m_busy[issue_addr] = 1;
      if (g >= 0) begin
        m_ptr   = (g + 1) % NREQ;
        m_wen   = 1;
        m_waddr = int'(req_addr[g*AW +: AW]);
        m_wdata = int'(req_data[g*DW +: DW]);
      end else begin
        m_wen = 0;
      end
    end
    @(negedge clk);
  endtask

  int rr_exp[4] = '{1, 2, 3, 1};

  initial begin
    for (int r = 0; r < 16; r++) m_busy[r] = 0;
    RESET      = 1'b1;
    req_valid  = 3'b111;
    req_addr   = {4'd3, 4'd2, 4'd1};
    req_data   = {16'hA003, 16'hA002, 16'hA001};
    issue_en   = 1'b0;
    issue_addr = '0;
    chk_addrA  = '0;
    chk_addrB  = '0;
    // Let the first reset edge initialise the DUT before comparing.
    @(posedge clk);
    @(negedge clk);

    // Reset held with all requesters valid
    #1;
    chk("rst_req_ready", req_ready, 3'b000);
    chk("rst_issue_ready", issue_ready, 1'b0);
    cycle();
    cycle();
    chk("rst_busy", busy, 16'h0000);
    chk("rst_wen", rf_write_en, 1'b0);

    // Round robin with all three valid; writes lag grants by one cycle
    RESET = 1'b0;
    #1;
    chk("first_grant", req_ready, 3'b001);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        #1;
        chk("rr_wen", rf_write_en, 1'b1);
        chk("rr_addr", rf_write_addr, rr_exp[k-1]);
      end
      cycle();
    end

    // Pointer wrap: requester 2 alone, then 0 and 2 contend -> 0 wins
    req_valid = 3'b100;
    cycle();
    req_valid = 3'b101;
    #1;
    chk("wrap_grant", req_ready, 3'b001);
    cycle();

    // Scoreboard set / hazard / clear on r5
    req_valid  = 3'b000;
    issue_en   = 1'b1;
    issue_addr = 4'd5;
    cycle();
    issue_en  = 1'b0;
    chk_addrA = 4'd5;
    #1;
    chk("sb_busy5", busy[5], 1'b1);
    chk("sb_hazard_set", hazard, 1'b1);
    cycle();
    req_valid        = 3'b010;
    req_addr[4 +: 4] = 4'd5;
    req_data[16 +: 16] = 16'h1234;
    cycle();
    req_valid = 3'b000;
    #1;
    chk("sb_wr_en", rf_write_en, 1'b1);
    chk("sb_wr_data", rf_write_data, 16'h1234);
`ifndef WB_BYPASS_EN
    chk("sb_hazard_inflight", hazard, 1'b1);
`endif
    cycle();
    #1;
    chk("sb_busy5_clr", busy[5], 1'b0);
    chk("sb_hazard_clr", hazard, 1'b0);
    cycle();
    chk_addrA = 4'd0;

    // WAW stall, then re-reservation in the completing-write cycle
    issue_en   = 1'b1;
    issue_addr = 4'd7;
    cycle();
    #1;
    chk("waw_stall", issue_ready, 1'b0);
    cycle();
    req_valid       = 3'b001;
    req_addr[0 +: 4] = 4'd7;
    cycle();
    req_valid = 3'b000;
    #1;
    chk("waw_same_cycle", issue_ready, 1'b1);
    cycle();
    issue_en = 1'b0;
    #1;
    chk("waw_set_wins", busy[7], 1'b1);
    cycle();

    // In-flight write on r4 seen through read port B
    issue_en   = 1'b1;
    issue_addr = 4'd4;
    cycle();
    issue_en           = 1'b0;
    chk_addrB          = 4'd4;
    req_valid          = 3'b100;
    req_addr[8 +: 4]   = 4'd4;
    req_data[32 +: 16] = 16'hBEEF;
    cycle();
    req_valid = 3'b000;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_B", bypassB, 1'b1);
    chk("byp_data", bypass_data, 16'hBEEF);
    chk("byp_hazard", hazard, 1'b0);
`else
    chk("nobyp_hazard", hazard, 1'b1);
`endif
    cycle();

    // Random traffic; requesters keep their request stable until granted
    for (int n = 0; n < 400; n++) begin
      RESET = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]          = 1'b1;
          req_addr[i*AW +: AW]  = 4'($urandom);
          req_data[i*DW +: DW]  = 16'($urandom);
        end
      end
      issue_en   = ($urandom_range(0, 2) == 0);
      issue_addr = 4'($urandom);
      chk_addrA  = 4'($urandom);
      chk_addrB  = 4'($urandom);
      cycle();
      if (last_g >= 0) req_valid[last_g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
